// File: rtl/data_mem_be.sv
// Byte-addressable data memory with byte/half/word access, configurable load latency,
// misalignment/range error responses and a post-reset clear sweep.
module data_mem_be #(
  parameter int DEPTH    = 2048,
  parameter int READ_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        init_busy_o
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_WORD  = AW'(DEPTH - 1);
  localparam logic [1:0]      WAIT_START = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] sweep;
  logic [1:0]    wait_cnt;
  logic [31:0]   ld_data;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          req_err;
  logic          accept;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  assign word_idx = req_addr_i[AW+1:2];
  assign lane     = req_addr_i[1:0];
  assign accept   = !rst_i && (state == IDLE) && req_valid_i;

  // Out-of-range address bits, misalignment and the illegal size all fault.
  assign req_err = ((req_addr_i >> (AW + 2)) != 32'd0)
                 | ((req_size_i == 2'b01) & lane[0])
                 | ((req_size_i == 2'b10) & (lane != 2'b00))
                 |  (req_size_i == 2'b11);

  assign rd_word = mem[word_idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ld_ext = rd_word;
    unique case (req_size_i)
      2'b00:   ld_ext = {{24{~req_unsigned_i & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~req_unsigned_i & ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    st_be   = 4'hF;
    st_data = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata_i[15:0]}};
      end
      default: begin
        st_be   = 4'hF;
        st_data = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = st_be;
    wr_data = st_data;
    if (!rst_i && state == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep;
      wr_be   = 4'hF;
      wr_data = 32'd0;
    end else if (accept && req_we_i && !req_err) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it, which keeps it mappable to RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      sweep       <= '0;
      wait_cnt    <= 2'd0;
      ld_data     <= 32'd0;
      req_ready_o <= 1'b0;
      init_busy_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'd0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'd0;
      unique case (state)
        INIT: begin
          sweep <= sweep + AW'(1);
          if (sweep == LAST_WORD) begin
            state       <= IDLE;
            init_busy_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            if (req_err || req_we_i || READ_LAT == 1) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= req_err;
              rsp_rdata_o <= (req_err || req_we_i) ? 32'd0 : ld_ext;
            end else begin
              // Load data is extended at acceptance so later input changes cannot affect it.
              state    <= RD_WAIT;
              wait_cnt <= WAIT_START;
              ld_data  <= ld_ext;
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= ld_data;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed self-checking bench for data_mem_be: a READ_LAT=3 instance is checked cycle by
// cycle, and a READ_LAT=1 instance on the same inputs is checked for single-cycle responses.
module tb_data_mem_be;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        ready, rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;
  logic        ready_l1, rsp_valid_l1, rsp_err_l1, init_busy_l1;
  logic [31:0] rsp_rdata_l1;

  int checks = 0;
  int errors = 0;

  data_mem_be #(.DEPTH(DEPTH), .READ_LAT(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .init_busy_o(init_busy)
  );

  data_mem_be #(.DEPTH(DEPTH), .READ_LAT(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(ready_l1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_l1), .rsp_rdata_o(rsp_rdata_l1), .rsp_err_o(rsp_err_l1),
    .init_busy_o(init_busy_l1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge where rst has just been released; counts the sweep cycles.
  task automatic sweep_check(input string tag);
    int cnt;
    logic seen;
    cnt  = 0;
    seen = 1'b0;
    while (init_busy && cnt < 40) begin
      cnt++;
      if (rsp_valid || ready) seen = 1'b1;
      @(negedge clk);
    end
    check({tag, ":busy_cycles"}, 32'(cnt), 32'd16);
    check({tag, ":quiet_sweep"}, 32'(seen), 32'd0);
    check({tag, ":ready"}, 32'(ready), 32'd1);
    check({tag, ":ready_l1"}, 32'(ready_l1), 32'd1);
    check({tag, ":busy_l1"}, 32'(init_busy_l1), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, ":rst_busy"}, 32'(init_busy), 32'd1);
    check({tag, ":rst_ready"}, 32'(ready), 32'd0);
    check({tag, ":rst_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":rst_rdata"}, rsp_rdata, 32'd0);
    check({tag, ":rst_err"}, 32'(rsp_err), 32'd0);
    rst = 1'b0;
    sweep_check(tag);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
    int waits;
    int lat;
    waits = 0;
    while (!ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check({tag, ":ready"}, 32'(ready), 32'd1);
    check({tag, ":ready_l1"}, 32'(ready_l1), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    lat = (we || exp_err) ? 1 : 3;
    @(negedge clk);
    // Scramble the inputs after acceptance; the response must not follow them.
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'hFFFF_FFFC;
    req_size     = 2'b11;
    req_unsigned = ~uns;
    req_wdata    = 32'hA5A5_A5A5;
    check({tag, ":l1_valid"}, 32'(rsp_valid_l1), 32'd1);
    check({tag, ":l1_err"}, 32'(rsp_err_l1), 32'(exp_err));
    check({tag, ":l1_rdata"}, rsp_rdata_l1, exp_rdata);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      check({tag, ":valid"}, 32'(rsp_valid), 32'(k == lat));
      check({tag, ":busy_ready"}, 32'(ready), 32'd0);
      check({tag, ":err"}, 32'(rsp_err), (k == lat) ? 32'(exp_err) : 32'd0);
      check({tag, ":rdata"}, rsp_rdata, (k == lat) ? exp_rdata : 32'd0);
    end
    @(negedge clk);
    check({tag, ":post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":post_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'd0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    @(negedge clk);

    do_reset("por");
    do_req("lw0", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0000_0000);

    do_req("sw4",   1'b1, 32'h4, 2'b10, 1'b0, 32'h8899_AABB, 1'b0, 32'h0);
    do_req("sb6",   1'b1, 32'h6, 2'b00, 1'b0, 32'hCAFE_0011, 1'b0, 32'h0);
    do_req("lw4",   1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 1'b0, 32'h8811_AABB);
    do_req("lb7",   1'b0, 32'h7, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFF_FF88);
    do_req("lbu7",  1'b0, 32'h7, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0000_0088);
    do_req("lh4",   1'b0, 32'h4, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFF_AABB);
    do_req("lhu6",  1'b0, 32'h6, 2'b01, 1'b1, 32'h0, 1'b0, 32'h0000_8811);
    do_req("lh6",   1'b0, 32'h6, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFF_8811);
    do_req("lb4",   1'b0, 32'h4, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFBB);
    do_req("lbu5",  1'b0, 32'h5, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0000_00AA);
    do_req("lw4u",  1'b0, 32'h4, 2'b10, 1'b1, 32'h0, 1'b0, 32'h8811_AABB);

    do_req("sha",   1'b1, 32'hA, 2'b01, 1'b0, 32'h5555_1234, 1'b0, 32'h0);
    do_req("sb8",   1'b1, 32'h8, 2'b00, 1'b0, 32'h1111_117F, 1'b0, 32'h0);
    do_req("lw8",   1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1234_007F);
    do_req("lha",   1'b0, 32'hA, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0000_1234);
    do_req("lb8",   1'b0, 32'h8, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0000_007F);
    do_req("lb9",   1'b0, 32'h9, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0000_0000);

    do_req("e_sh5",  1'b1, 32'h5,         2'b01, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    do_req("e_lw2",  1'b0, 32'h2,         2'b10, 1'b0, 32'h0,         1'b1, 32'h0);
    do_req("e_sz3",  1'b1, 32'h8,         2'b11, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    do_req("e_sw64", 1'b1, 32'd64,        2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0);
    do_req("e_hi",   1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'h0,         1'b1, 32'h0);
    do_req("e_lh3",  1'b0, 32'h3,         2'b01, 1'b0, 32'h0,         1'b1, 32'h0);
    do_req("keep4",  1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 1'b0, 32'h8811_AABB);
    do_req("keep8",  1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1234_007F);
    do_req("keep0",  1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0000_0000);

    // Reset lands in the load's RD_WAIT cycle: no response, full sweep again, memory cleared.
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = 32'h4;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rdw:in_wait", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rdw:no_valid", 32'(rsp_valid), 32'd0);
    check("rdw:busy", 32'(init_busy), 32'd1);
    check("rdw:ready", 32'(ready), 32'd0);
    rst = 1'b0;
    sweep_check("rdw");
    do_req("rdw_lw4", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
